// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings and lane helpers for the two-requester RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int WORD_BYTES = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // Lane mask of an access of the given size placed at lane 0.
  function automatic logic [WORD_BYTES-1:0] size_lanes(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Bit mask keeping only the bytes covered by an access of the given size.
  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 32'h0000_00FF;
      SZ_H:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/ram_port_arbiter_lane_split.sv
// Lane placement for one RAM access: positions the request across two
// consecutive words and returns the half belonging to the requested phase.
module ram_lane_split
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0]  k,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic        phase,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata_sh,
  output logic        split
);

  logic [2*WORD_BYTES-1:0] mask2w;
  logic [63:0]             data2w;

  // Shift the request into a two-word window; the upper word is the spill-over.
  always_comb begin
    mask2w    = {4'b0000, size_lanes(size)} << k;
    data2w    = {32'h0, wdata} << {k, 3'b000};
    split     = |mask2w[7:4];
    lane_mask = phase ? mask2w[7:4] : mask2w[3:0];
    wdata_sh  = phase ? data2w[63:32] : data2w[31:0];
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one aligned RAM port between two requesters;
// misaligned accesses crossing a word are split into two word accesses.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int SCALE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  output logic             gnt0,
  input  logic             wr0,
  input  logic [1:0]       size0,
  input  logic [SCALE-1:0] addr0,
  input  logic [31:0]      wdata0,
  output logic             done0,
  output logic [31:0]      rdata0,
  input  logic             req1,
  output logic             gnt1,
  input  logic             wr1,
  input  logic [1:0]       size1,
  input  logic [SCALE-1:0] addr1,
  input  logic [31:0]      wdata1,
  output logic             done1,
  output logic [31:0]      rdata1,
  output logic             ram_oe,
  output logic [SCALE-1:0] ram_addr,
  output logic [3:0]       ram_we,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata
);

  state_t state, state_n;
  logic   rr_last;

  logic             sel, sel_wr, issue_p0;
  logic [1:0]       sel_size;
  logic [SCALE-1:0] sel_addr;
  logic [31:0]      sel_wdata;

  logic             wr_s, own_s;
  logic [1:0]       size_s, k_s;
  logic [31:0]      wdata_s;
  logic [SCALE-3:0] word_s, word_nxt;

  logic        ls_phase, ls_split;
  logic [1:0]  ls_k, ls_size;
  logic [31:0] ls_wdata, ls_wdata_sh;
  logic [3:0]  ls_mask;

  logic        vld_p1, own_p1, wr_p1, split_p1;
  logic [1:0]  size_p1, k_p1;
  logic [31:0] lo_p1, rd_raw, rd_val;
  logic [4:0]  rd_sh;

  // Pick the requester: a tie goes to the one that did not win last.
  always_comb begin
    sel       = (req0 && req1) ? ~rr_last : req1;
    sel_wr    = sel ? wr1 : wr0;
    sel_size  = sel ? size1 : size0;
    sel_addr  = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
  end

  assign issue_p0 = (state == ST_IDLE) && rst && (req0 || req1);
  assign word_nxt = word_s + (SCALE-2)'(1);

  assign ls_phase = (state == ST_SPLIT);
  assign ls_k     = ls_phase ? k_s : sel_addr[1:0];
  assign ls_size  = ls_phase ? size_s : sel_size;
  assign ls_wdata = ls_phase ? wdata_s : sel_wdata;

  ram_lane_split u_lane_split (
    .k         (ls_k),
    .size      (ls_size),
    .wdata     (ls_wdata),
    .phase     (ls_phase),
    .lane_mask (ls_mask),
    .wdata_sh  (ls_wdata_sh),
    .split     (ls_split)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next state, grants and the RAM port drive for the current access.
  always_comb begin
    state_n   = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ram_oe    = 1'b0;
    ram_addr  = '0;
    ram_we    = 4'b0000;
    ram_wdata = 32'h0;
    case (state)
      ST_IDLE: begin
        if (issue_p0) begin
          gnt0      = ~sel;
          gnt1      = sel;
          ram_oe    = 1'b1;
          ram_addr  = {sel_addr[SCALE-1:2], 2'b00};
          ram_we    = sel_wr ? ls_mask : 4'b0000;
          ram_wdata = ls_wdata_sh;
          if (ls_split) state_n = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        state_n = ST_IDLE;
        if (rst) begin
          ram_oe    = 1'b1;
          ram_addr  = {word_nxt, 2'b00};
          ram_we    = wr_s ? ls_mask : 4'b0000;
          ram_wdata = ls_wdata_sh;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Round-robin history moves only when both requesters competed.
  always_ff @(posedge clk) begin
    if (!rst)                         rr_last <= 1'b1;
    else if (issue_p0 && req0 && req1) rr_last <= sel;
  end

  // Hold the granted request for the second half of a split access.
  always_ff @(posedge clk) begin
    if (issue_p0 && ls_split) begin
      wr_s    <= sel_wr;
      size_s  <= sel_size;
      k_s     <= sel_addr[1:0];
      wdata_s <= sel_wdata;
      own_s   <= sel;
      word_s  <= sel_addr[SCALE-1:2];
    end
  end

  // ---- stage p0 -> p1: last RAM access issued, completion pending ----
  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= (issue_p0 && !ls_split) || (state == ST_SPLIT);
  end

  // Attributes of the pending completion, plus the low word of a split read.
  always_ff @(posedge clk) begin
    if (state == ST_SPLIT) begin
      own_p1   <= own_s;
      wr_p1    <= wr_s;
      size_p1  <= size_s;
      k_p1     <= k_s;
      split_p1 <= 1'b1;
      lo_p1    <= ram_rdata;
    end else begin
      own_p1   <= sel;
      wr_p1    <= sel_wr;
      size_p1  <= sel_size;
      k_p1     <= sel_addr[1:0];
      split_p1 <= 1'b0;
    end
  end

  // Right-align the returned bytes, merging both words for a split read.
  always_comb begin
    rd_sh  = {k_p1, 3'b000};
    rd_raw = split_p1 ? ((lo_p1 >> rd_sh) | (ram_rdata << (6'd32 - {1'b0, rd_sh})))
                      : (ram_rdata >> rd_sh);
    rd_val = rd_raw & size_mask(size_p1);
    done0  = rst && vld_p1 && !own_p1;
    done1  = rst && vld_p1 && own_p1;
    rdata0 = (done0 && !wr_p1) ? rd_val : 32'h0;
    rdata1 = (done1 && !wr_p1) ? rd_val : 32'h0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, corner sequences and a
// randomized run against a byte-level memory model.
module tb_ram_port_arbiter;

  localparam int SCALE = 10;
  localparam int MEMB  = 1 << SCALE;

  logic             clk, rst;
  logic             req0, gnt0, wr0, done0;
  logic [1:0]       size0;
  logic [SCALE-1:0] addr0;
  logic [31:0]      wdata0, rdata0;
  logic             req1, gnt1, wr1, done1;
  logic [1:0]       size1;
  logic [SCALE-1:0] addr1;
  logic [31:0]      wdata1, rdata1;
  logic             ram_oe;
  logic [SCALE-1:0] ram_addr;
  logic [3:0]       ram_we;
  logic [31:0]      ram_wdata, ram_rdata;

  logic             pl_en;
  logic [SCALE-1:0] pl_addr;
  logic [31:0]      pl_data;

  logic [7:0] ram_mem [MEMB];
  logic [7:0] ref_mem [MEMB];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        id;
    logic        wr;
    logic [1:0]  size;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        split;
    logic [9:0]  a1;
    logic [3:0]  we1;
    logic [31:0] wd1;
    logic [9:0]  a2;
    logic [3:0]  we2;
    logic [31:0] wd2;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[13];

  ram_port_arbiter #(.SCALE(SCALE)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .gnt0(gnt0), .wr0(wr0), .size0(size0), .addr0(addr0),
    .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .gnt1(gnt1), .wr1(wr1), .size1(size1), .addr1(addr1),
    .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
    .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, per-lane write, plus a preload port.
  always @(posedge clk) begin
    int a;
    if (ram_oe) begin
      a = int'(ram_addr) & (MEMB - 4);
      ram_rdata <= {ram_mem[a+3], ram_mem[a+2], ram_mem[a+1], ram_mem[a]};
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram_mem[a+i] = ram_wdata[8*i +: 8];
    end
    if (pl_en)
      for (int i = 0; i < 4; i++) ram_mem[(int'(pl_addr) & (MEMB - 4)) + i] = pl_data[8*i +: 8];
  end

  // Illegal size while running stops the simulation.
  always @(posedge clk) begin
    if (rst && ((req0 && size0 == 2'd3) || (req1 && size1 == 2'd3))) begin
      $display("FAIL size3 illegal request size seen");
      $fatal(1, "illegal size");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic id, input logic r, input logic w, input logic [1:0] s,
                       input logic [9:0] a, input logic [31:0] d);
    if (!id) begin req0 = r; wr0 = w; size0 = s; addr0 = a; wdata0 = d; end
    else     begin req1 = r; wr1 = w; size1 = s; addr1 = a; wdata1 = d; end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One isolated transaction from a table record; starts just after a rising edge.
  task automatic txn(input vec_t v);
    drive(v.id, 1'b1, v.wr, v.size, v.addr, v.wdata);
    @(negedge clk);
    chk("tx_gnt",   32'(v.id ? gnt1 : gnt0), 32'd1);
    chk("tx_ngnt",  32'(v.id ? gnt0 : gnt1), 32'd0);
    chk("tx_oe",    32'(ram_oe), 32'd1);
    chk("tx_addr1", 32'(ram_addr), 32'(v.a1));
    chk("tx_we1",   32'(ram_we), 32'(v.we1));
    chk("tx_wd1",   ram_wdata, v.wd1);
    @(posedge clk); #1;
    drive(v.id, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    if (v.split) begin
      @(negedge clk);
      chk("tx_split_nogrant", 32'({gnt1, gnt0}), 32'd0);
      chk("tx_addr2", 32'(ram_addr), 32'(v.a2));
      chk("tx_we2",   32'(ram_we), 32'(v.we2));
      chk("tx_wd2",   ram_wdata, v.wd2);
      chk("tx_early_done", 32'({done1, done0}), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tx_done",   32'(v.id ? done1 : done0), 32'd1);
    chk("tx_ndone",  32'(v.id ? done0 : done1), 32'd0);
    chk("tx_rdata",  v.id ? rdata1 : rdata0, v.rd);
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input logic id, input logic [1:0] s, input logic [9:0] a, input logic [31:0] exp);
    vec_t v;
    v = '{id, 1'b0, s, a, 32'h0, 1'b0, a & 10'h3FC, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, exp};
    txn(v);
  endtask

  task automatic check_done(input int id, input int cyc);
    logic d;
    logic [31:0] r;
    exp_t e;
    logic has;
    d = id ? done1 : done0;
    r = id ? rdata1 : rdata0;
    has = 1'b0;
    if (id == 0 && q0.size() > 0 && q0[0].due == cyc) begin has = 1'b1; e = q0.pop_front(); end
    if (id == 1 && q1.size() > 0 && q1[0].due == cyc) begin has = 1'b1; e = q1.pop_front(); end
    if (has) begin
      chk(id ? "rnd_done1" : "rnd_done0", 32'(d), 32'd1);
      chk(id ? "rnd_rdata1" : "rnd_rdata0", r, e.rd);
    end else begin
      chk(id ? "rnd_quiet_done1" : "rnd_quiet_done0", 32'(d), 32'd0);
      chk(id ? "rnd_quiet_rdata1" : "rnd_quiet_rdata0", r, 32'h0);
    end
  endtask

  // Random traffic from both requesters against a byte-array memory model.
  task automatic run_random(input int ncyc);
    logic        act [2];
    logic        aw  [2];
    logic [1:0]  asz [2];
    logic [9:0]  aad [2];
    logic [31:0] awd [2];
    logic        rr, blocked, sp;
    int          g, n, base;
    logic [31:0] v;
    exp_t        e;
    rr = 1'b1; blocked = 1'b0;
    for (int i = 0; i < 2; i++) act[i] = 1'b0;
    for (int c = 0; c < ncyc + 8; c++) begin
      for (int i = 0; i < 2; i++)
        if (!act[i] && c < ncyc && $urandom_range(0, 3) != 0) begin
          act[i] = 1'b1;
          aw[i]  = 1'($urandom_range(0, 1));
          asz[i] = 2'($urandom_range(0, 2));
          aad[i] = 10'($urandom);
          awd[i] = $urandom;
        end
      for (int i = 0; i < 2; i++) drive(1'(i), act[i], aw[i], asz[i], aad[i], awd[i]);
      @(negedge clk);
      g = -1;
      if (!blocked) begin
        if (act[0] && act[1]) begin g = rr ? 0 : 1; rr = (g == 1); end
        else if (act[0]) g = 0;
        else if (act[1]) g = 1;
      end
      chk("rnd_gnt0", 32'(gnt0), 32'(g == 0));
      chk("rnd_gnt1", 32'(gnt1), 32'(g == 1));
      check_done(0, c);
      check_done(1, c);
      if (ram_oe) chk("rnd_addr_aligned", 32'(ram_addr[1:0]), 32'd0);
      else        chk("rnd_we_idle", 32'(ram_we), 32'd0);
      blocked = 1'b0;
      if (g >= 0) begin
        n = nbytes(asz[g]);
        base = int'(aad[g]);
        sp = ((base % 4) + n) > 4;
        v = 32'h0;
        for (int b = 0; b < n; b++) begin
          if (aw[g]) ref_mem[(base + b) % MEMB] = awd[g][8*b +: 8];
          else       v[8*b +: 8] = ref_mem[(base + b) % MEMB];
        end
        e.due = c + (sp ? 2 : 1);
        e.rd  = v;
        if (g == 0) q0.push_back(e); else q1.push_back(e);
        act[g] = 1'b0;
        blocked = sp;
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    chk("rnd_drain", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    drive(1'b0, 1'b1, 1'b0, 2'd2, 10'h004, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 2'd2, 10'h008, 32'h1234_5678);
    @(negedge clk);
    chk("rst_gnt",   32'({gnt1, gnt0}), 32'd0);
    chk("rst_done",  32'({done1, done0}), 32'd0);
    chk("rst_oe",    32'(ram_oe), 32'd0);
    chk("rst_we",    32'(ram_we), 32'd0);
    chk("rst_rdata", rdata0 | rdata1, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    for (int w = 0; w < MEMB / 4; w++) preload(10'(w * 4), $urandom);
    do_reset();

    // Contention: alternating grants, then a split write from requester 1.
    drive(1'b0, 1'b1, 1'b0, 2'd2, 10'h004, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 10'h000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cont_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      chk("cont_gnt1", 32'(gnt1), 32'(i % 2 == 1));
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b1, 1'b1, 2'd1, 10'h0FF, 32'h0000_BEEF);
    @(negedge clk);
    chk("cont_split_gnt1", 32'({gnt1, gnt0}), 32'd2);
    chk("cont_split_addr1", 32'(ram_addr), 32'h0FC);
    chk("cont_split_we1", 32'(ram_we), 32'h8);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 2'd2, 10'h000, 32'h0);
    @(negedge clk);
    chk("cont_split_nogrant", 32'({gnt1, gnt0}), 32'd0);
    chk("cont_split_addr2", 32'(ram_addr), 32'h100);
    chk("cont_split_we2", 32'(ram_we), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cont_after_split", 32'({gnt1, gnt0}), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    rd_chk(1'b0, 2'd0, 10'h0FF, 32'h0000_00EF);
    rd_chk(1'b1, 2'd0, 10'h100, 32'h0000_00BE);

    // Directed vector table.
    preload(10'h100, 32'h4433_2211);
    preload(10'h104, 32'h8877_6655);
    preload(10'h3FC, 32'hDDCC_BBAA);
    preload(10'h000, 32'h1122_3344);
    tbl[0]  = '{1'b0, 1'b1, 2'd2, 10'h004, 32'hDEADBEEF, 1'b0, 10'h004, 4'hF, 32'hDEADBEEF, 10'h000, 4'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 2'd2, 10'h004, 32'h0,        1'b0, 10'h004, 4'h0, 32'h0,        10'h000, 4'h0, 32'h0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b0, 2'd2, 10'h101, 32'h0,        1'b1, 10'h100, 4'h0, 32'h0,        10'h104, 4'h0, 32'h0, 32'h55443322};
    tbl[3]  = '{1'b1, 1'b1, 2'd0, 10'h103, 32'h000000AA, 1'b0, 10'h100, 4'h8, 32'hAA000000, 10'h000, 4'h0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 2'd2, 10'h100, 32'h0,        1'b0, 10'h100, 4'h0, 32'h0,        10'h000, 4'h0, 32'h0, 32'hAA332211};
    tbl[5]  = '{1'b0, 1'b0, 2'd2, 10'h3FE, 32'h0,        1'b1, 10'h3FC, 4'h0, 32'h0,        10'h000, 4'h0, 32'h0, 32'h3344DDCC};
    tbl[6]  = '{1'b1, 1'b1, 2'd1, 10'h0FF, 32'h0000BEEF, 1'b1, 10'h0FC, 4'h8, 32'hEF000000, 10'h100, 4'h1, 32'h000000BE, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 10'h0FF, 32'h0,        1'b0, 10'h0FC, 4'h0, 32'h0,        10'h000, 4'h0, 32'h0, 32'h000000EF};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 10'h100, 32'h0,        1'b0, 10'h100, 4'h0, 32'h0,        10'h000, 4'h0, 32'h0, 32'h000000BE};
    tbl[9]  = '{1'b1, 1'b0, 2'd1, 10'h102, 32'h0,        1'b0, 10'h100, 4'h0, 32'h0,        10'h000, 4'h0, 32'h0, 32'h0000AA33};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 10'h3FF, 32'h00001234, 1'b1, 10'h3FC, 4'h8, 32'h34000000, 10'h000, 4'h1, 32'h00000012, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 2'd2, 10'h3FC, 32'h0,        1'b0, 10'h3FC, 4'h0, 32'h0,        10'h000, 4'h0, 32'h0, 32'h34CCBBAA};
    tbl[12] = '{1'b1, 1'b0, 2'd1, 10'h000, 32'h0,        1'b0, 10'h000, 4'h0, 32'h0,        10'h000, 4'h0, 32'h0, 32'h00003312};
    for (int i = 0; i < 13; i++) txn(tbl[i]);

    // Reset during the second half of a split write.
    drive(1'b0, 1'b1, 1'b1, 2'd2, 10'h102, 32'hCAFEF00D);
    @(negedge clk);
    chk("rsplit_gnt", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 10'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rsplit_oe_in_reset", 32'(ram_oe), 32'd0);
    chk("rsplit_we_in_reset", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rsplit_oe_after", 32'(ram_oe), 32'd0);
    chk("rsplit_done_after", 32'({done1, done0}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsplit_done_later", 32'({done1, done0}), 32'd0);
    chk("rsplit_mem104", {ram_mem[10'h107], ram_mem[10'h106], ram_mem[10'h105], ram_mem[10'h104]}, 32'h88776655);
    @(posedge clk); #1;
    rd_chk(1'b0, 2'd2, 10'h104, 32'h88776655);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < MEMB; i++) ref_mem[i] = ram_mem[i];
    run_random(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
